// File: rtl/pht_ctrl_if.sv
// pht_ctrl_if: lookup, update and counter-FSM handshake bundle for pht_ctrl.
interface pht_ctrl_if #(parameter int IDX_W = 4);
    logic             lk_valid;
    logic [IDX_W-1:0] lk_pc;
    logic             pred_valid;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_idx;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_torn;
    logic             upd_ready;
    logic             fsm_torn;
    logic [1:0]       fsm_data;
    logic             fsm_wr_en;
    logic [1:0]       fsm_out_data;
    logic [IDX_W-1:0] ghr;
    logic             err;

    modport master (
        output lk_valid, lk_pc, upd_valid, upd_idx, upd_torn, fsm_wr_en, fsm_out_data,
        input  pred_valid, pred_taken, pred_idx, upd_ready, fsm_torn, fsm_data, ghr, err
    );
    modport slave (
        input  lk_valid, lk_pc, upd_valid, upd_idx, upd_torn, fsm_wr_en, fsm_out_data,
        output pred_valid, pred_taken, pred_idx, upd_ready, fsm_torn, fsm_data, ghr, err
    );
endinterface

// File: rtl/pht_ctrl.sv
// pht_ctrl: gshare pattern history table with a present/wait update sequencer for fin_sta_mac.
module pht_ctrl #(
    parameter int         IDX_W    = 4,
    parameter logic [1:0] INIT_CNT = 2'b01,
    parameter int         TMO      = 8
) (
    input logic        clk,
    input logic        reset,
    pht_ctrl_if.slave  bus
);
    localparam int CW = $clog2(TMO + 1);
    typedef enum logic [1:0] {IDLE, PRES, WAIT} state_t;
    state_t           state;
    logic [1:0]       tbl [2**IDX_W];
    logic [IDX_W-1:0] ghr, cap_idx, lk_idx;
    logic             cap_torn, wr;
    logic [CW-1:0]    tmo_cnt;
    assign lk_idx        = bus.lk_pc ^ ghr;
    assign wr            = state == WAIT && bus.fsm_wr_en;
    assign bus.upd_ready = state == IDLE;
    assign bus.ghr       = ghr;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2**IDX_W; i++) tbl[i] <= INIT_CNT;
            ghr            <= '0;
            state          <= IDLE;
            bus.pred_valid <= 1'b0;
            bus.pred_taken <= 1'b0;
            bus.pred_idx   <= '0;
            bus.fsm_torn   <= 1'b0;
            bus.fsm_data   <= 2'b00;
            bus.err        <= 1'b0;
            cap_idx        <= '0;
            cap_torn       <= 1'b0;
            tmo_cnt        <= '0;
        end else begin
            bus.pred_valid <= bus.lk_valid;
            // a same-edge write to the looked-up entry wins over the stale table value
            if (bus.lk_valid) begin
                bus.pred_idx   <= lk_idx;
                bus.pred_taken <= (wr && cap_idx == lk_idx) ? bus.fsm_out_data[1] : tbl[lk_idx][1];
            end
            case (state)
                IDLE: if (bus.upd_valid) begin
                    cap_idx      <= bus.upd_idx;
                    cap_torn     <= bus.upd_torn;
                    bus.fsm_data <= tbl[bus.upd_idx];
                    bus.fsm_torn <= bus.upd_torn;
                    state        <= PRES;
                end
                PRES: begin
                    tmo_cnt <= '0;
                    state   <= WAIT;
                end
                WAIT: if (bus.fsm_wr_en) begin
                    tbl[cap_idx] <= bus.fsm_out_data;
                    ghr          <= {ghr[IDX_W-2:0], cap_torn};
                    state        <= IDLE;
                end else if (tmo_cnt == CW'(TMO - 1)) begin
                    bus.err <= 1'b1;
                    state   <= IDLE;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pht_ctrl.sv
// tb_pht_ctrl: directed checks of lookup, bypass, update, backpressure, timeout and reset.
module tb_pht_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    pht_ctrl_if #(.IDX_W(4)) bus ();
    pht_ctrl #(.IDX_W(4), .INIT_CNT(2'b01), .TMO(8)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        bus.lk_valid = 0; bus.lk_pc = 0; bus.upd_valid = 0; bus.upd_idx = 0; bus.upd_torn = 0;
        bus.fsm_wr_en = 0; bus.fsm_out_data = 0;
        tick(); tick();
        chk("rst_ready", bus.upd_ready, 1);
        chk("rst_pvalid", bus.pred_valid, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_ghr", bus.ghr, 0);
        chk("rst_fdata", bus.fsm_data, 0);
        reset = 1;
        tick();
        bus.lk_valid = 1; bus.lk_pc = 4'h3;
        tick();
        chk("lk0_valid", bus.pred_valid, 1);
        chk("lk0_taken", bus.pred_taken, 0);
        chk("lk0_idx", bus.pred_idx, 4'h3);
        bus.lk_valid = 0;
        tick();
        chk("lk0_drop", bus.pred_valid, 0);
        // single update of entry 3, taken; counter 01 -> 10
        bus.upd_valid = 1; bus.upd_idx = 4'h3; bus.upd_torn = 1;
        tick();
        bus.upd_valid = 0;
        chk("pres_ready", bus.upd_ready, 0);
        chk("pres_fdata", bus.fsm_data, 2'b01);
        chk("pres_ftorn", bus.fsm_torn, 1);
        tick();
        chk("wait_fdata", bus.fsm_data, 2'b01);
        chk("wait_ftorn", bus.fsm_torn, 1);
        bus.fsm_wr_en = 1; bus.fsm_out_data = 2'b10;
        bus.lk_valid = 1; bus.lk_pc = 4'h3;
        tick();
        chk("byp_taken", bus.pred_taken, 1);
        chk("byp_idx", bus.pred_idx, 4'h3);
        chk("upd_ghr", bus.ghr, 4'b0001);
        chk("upd_ready", bus.upd_ready, 1);
        bus.fsm_wr_en = 0; bus.lk_pc = 4'h2;
        tick();
        chk("lk1_taken", bus.pred_taken, 1);
        chk("lk1_idx", bus.pred_idx, 4'h3);
        bus.lk_valid = 0;
        // backpressure: first request idx 5, then a different request held through WAIT
        bus.upd_valid = 1; bus.upd_idx = 4'h5; bus.upd_torn = 0;
        tick();
        bus.upd_idx = 4'h6; bus.upd_torn = 1;
        chk("bp_pres_ready", bus.upd_ready, 0);
        tick();
        chk("bp_wait_ready", bus.upd_ready, 0);
        chk("bp_wait_fdata", bus.fsm_data, 2'b01);
        chk("bp_wait_ftorn", bus.fsm_torn, 0);
        bus.fsm_wr_en = 1; bus.fsm_out_data = 2'b00;
        tick();
        bus.fsm_wr_en = 0;
        chk("bp_idle_ready", bus.upd_ready, 1);
        chk("bp_ghr", bus.ghr, 4'b0010);
        tick();
        bus.upd_valid = 0;
        chk("bp2_ready", bus.upd_ready, 0);
        chk("bp2_fdata", bus.fsm_data, 2'b01);
        chk("bp2_ftorn", bus.fsm_torn, 1);
        // timeout: no wr_en for 8 WAIT cycles
        tick();
        repeat (7) tick();
        chk("tmo_err_early", bus.err, 0);
        chk("tmo_ready_early", bus.upd_ready, 0);
        tick();
        chk("tmo_err", bus.err, 1);
        chk("tmo_ready", bus.upd_ready, 1);
        chk("tmo_ghr", bus.ghr, 4'b0010);
        // wr_en while IDLE is ignored; entry 6 (pc 4 ^ ghr 2) stays 01
        bus.fsm_wr_en = 1; bus.fsm_out_data = 2'b11;
        bus.lk_valid = 1; bus.lk_pc = 4'h4;
        tick();
        bus.fsm_wr_en = 0;
        chk("tmo_e6_taken", bus.pred_taken, 0);
        chk("tmo_e6_idx", bus.pred_idx, 4'h6);
        tick();
        chk("idle_wr_taken", bus.pred_taken, 0);
        chk("idle_wr_ghr", bus.ghr, 4'b0010);
        chk("err_sticky", bus.err, 1);
        bus.lk_valid = 0;
        // lookup entry 5 (pc 7 ^ ghr 2) which was written 00
        bus.lk_valid = 1; bus.lk_pc = 4'h7;
        tick();
        chk("e5_taken", bus.pred_taken, 0);
        chk("e5_idx", bus.pred_idx, 4'h5);
        bus.lk_valid = 0;
        // mid-update reset
        bus.upd_valid = 1; bus.upd_idx = 4'h3; bus.upd_torn = 1;
        tick();
        bus.upd_valid = 0;
        tick();
        chk("mr_wait_ready", bus.upd_ready, 0);
        reset = 0;
        #1;
        chk("mr_ready", bus.upd_ready, 1);
        chk("mr_ghr", bus.ghr, 0);
        chk("mr_err", bus.err, 0);
        chk("mr_fdata", bus.fsm_data, 0);
        tick();
        reset = 1;
        bus.fsm_wr_en = 1; bus.fsm_out_data = 2'b11;
        tick();
        bus.fsm_wr_en = 0;
        bus.lk_valid = 1; bus.lk_pc = 4'h3;
        tick();
        chk("mr_e3_taken", bus.pred_taken, 0);
        chk("mr_e3_idx", bus.pred_idx, 4'h3);
        chk("mr_ghr_after", bus.ghr, 0);
        bus.lk_valid = 0;
        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
